// File: rtl/paint_pkg.sv
// Shared constants and helpers for the brush paint controller: palette,
// FSM encoding, width helpers and the (x,y) -> (bank, address) mapping.
package paint_pkg;

  localparam logic [11:0] PAL_RED     = 12'hF00;
  localparam logic [11:0] PAL_GREEN   = 12'h0F0;
  localparam logic [11:0] PAL_YELLOW  = 12'hFF0;
  localparam logic [11:0] PAL_BLACK   = 12'h000;
  localparam logic [11:0] ERASE_COLOR = 12'hFFF;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RESTORE   = 3'd1;
  localparam logic [2:0] S_BRUSH     = 3'd2;
  localparam logic [2:0] S_SAVE_RD   = 3'd3;
  localparam logic [2:0] S_SAVE_WAIT = 3'd4;
  localparam logic [2:0] S_CURSOR    = 3'd5;

  typedef enum logic [1:0] {
    MODE_CURSOR = 2'd0,
    MODE_PAINT  = 2'd1,
    MODE_ERASE  = 2'd2
  } mode_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [11:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return PAL_RED;
      2'd1:    return PAL_GREEN;
      2'd2:    return PAL_YELLOW;
      default: return PAL_BLACK;
    endcase
  endfunction

  // Saturate a signed PS/2 coordinate into 0..lim-1.
  function automatic int clamp_coord(input logic signed [8:0] v, input int lim);
    int s;
    s = int'(v);
    if (s < 0) return 0;
    if (s > lim - 1) return lim - 1;
    return s;
  endfunction

  function automatic int map_bank(input int y, input int rows_per_bank);
    return y / rows_per_bank;
  endfunction

  function automatic int map_addr(input int x, input int y, input int cols,
                                  input int rows_per_bank);
    return (y % rows_per_bank) * cols + x;
  endfunction

endpackage

// File: rtl/brush_scan.sv
// Walks the (2r+1)x(2r+1) brush offsets, dy outer and dx inner, one offset
// per step, and reports the target pixel and whether it lies in the frame.
module brush_scan
  import paint_pkg::*;
#(
  parameter int COLS      = 64,
  parameter int ROWS      = 64,
  parameter int BRUSH_MAX = 3,
  localparam int RAD_W = clog2_min1(BRUSH_MAX + 1),
  localparam int XW    = $clog2(COLS),
  localparam int YW    = $clog2(ROWS)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [RAD_W-1:0] radius,
  input  logic [XW-1:0]    cx,
  input  logic [YW-1:0]    cy,
  output logic             in_frame,
  output logic [XW-1:0]    tx,
  output logic [YW-1:0]    ty,
  output logic             done
);

  logic [RAD_W-1:0]      r_q;
  logic signed [RAD_W:0] r_s;
  logic signed [RAD_W:0] dx, dy;
  logic                  last;
  int                    tx_i, ty_i;

  assign r_s  = $signed({1'b0, r_q});
  assign last = (dx == r_s) && (dy == r_s);
  assign done = step && last;

  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      dx  <= '0;
      dy  <= '0;
    end else if (start) begin
      r_q <= radius;
      dx  <= -$signed({1'b0, radius});
      dy  <= -$signed({1'b0, radius});
    end else if (step) begin
      if (dx == r_s) begin
        dx <= -r_s;
        if (!last) dy <= dy + 1;
      end else begin
        dx <= dx + 1;
      end
    end
  end

  // Off-frame offsets are flagged, never clamped or wrapped.
  always_comb begin
    tx_i     = int'(cx) + int'(dx);
    ty_i     = int'(cy) + int'(dy);
    in_frame = (tx_i >= 0) && (tx_i < COLS) && (ty_i >= 0) && (ty_i < ROWS);
  end

  assign tx = XW'(tx_i);
  assign ty = YW'(ty_i);

endmodule

// File: rtl/ctrl_paint_brush.sv
// Paint controller: turns cursor moves and button presses into restore,
// brush, background-save and cursor writes on a row-striped banked framebuffer.
module ctrl_paint_brush
  import paint_pkg::*;
#(
  parameter int COLS      = 64,
  parameter int ROWS      = 64,
  parameter int NUM_BANKS = 2,
  parameter int COLOR_W   = 12,
  parameter int BRUSH_MAX = 3,
  parameter int RD_LAT    = 1,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = '0,
  localparam int BANK_W = clog2_min1(NUM_BANKS),
  localparam int ADDR_W = $clog2(COLS * ROWS / NUM_BANKS),
  localparam int RAD_W  = clog2_min1(BRUSH_MAX + 1)
)(
  input  logic                clk,
  input  logic                reset,
  input  logic signed [8:0]   PS2_Xdata,
  input  logic signed [8:0]   PS2_Ydata,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_middle,
  input  logic                btn_size,
  output logic                rd_en,
  output logic [BANK_W-1:0]   rd_bank,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [COLOR_W-1:0]  rd_data,
  output logic                wr_en,
  output logic [BANK_W-1:0]   wr_bank,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [COLOR_W-1:0]  wr_data,
  output logic                paint_permanent,
  output logic                busy,
  output logic [1:0]          color_index,
  output logic [RAD_W-1:0]    brush_radius
);

  localparam int XW  = $clog2(COLS);
  localparam int YW  = $clog2(ROWS);
  localparam int RPB = ROWS / NUM_BANKS;

  logic [2:0]         state, state_nxt;
  logic [XW-1:0]      cur_x, pos_x, last_x, scan_tx;
  logic [YW-1:0]      cur_y, pos_y, last_y, scan_ty;
  mode_e              mode;
  logic [COLOR_W-1:0] color_lat, saved_bg;
  logic               saved_valid;
  logic               left_q, right_q, middle_q, size_q;
  logic [1:0]         wait_cnt;
  logic [RD_LAT-1:0]  cap_pipe;
  logic               trigger, scan_start, scan_step, scan_done, scan_in_frame;

  function automatic logic [BANK_W-1:0] bank_of(input logic [YW-1:0] y);
    return BANK_W'(map_bank(int'(y), RPB));
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [XW-1:0] x,
                                                input logic [YW-1:0] y);
    return ADDR_W'(map_addr(int'(x), int'(y), COLS, RPB));
  endfunction

  assign cur_x      = XW'(clamp_coord(PS2_Xdata, COLS));
  assign cur_y      = YW'(clamp_coord(PS2_Ydata, ROWS));
  assign trigger    = (cur_x != last_x) || (cur_y != last_y) ||
                      (btn_left && !left_q) || (btn_right && !right_q);
  assign scan_start = (state == S_IDLE) && trigger;
  assign scan_step  = (state == S_BRUSH);
  assign busy       = (state != S_IDLE);

  brush_scan #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .BRUSH_MAX (BRUSH_MAX)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .start    (scan_start),
    .step     (scan_step),
    .radius   (brush_radius),
    .cx       (pos_x),
    .cy       (pos_y),
    .in_frame (scan_in_frame),
    .tx       (scan_tx),
    .ty       (scan_ty),
    .done     (scan_done)
  );

  always_comb begin
    // NOTE: the default assignment up front covers every path through the
    // case, so no latch is inferred for state_nxt.
    state_nxt = state;
    case (state)
      S_IDLE:      if (trigger) state_nxt = S_RESTORE;
      S_RESTORE:   state_nxt = (mode == MODE_CURSOR) ? S_SAVE_RD : S_BRUSH;
      S_BRUSH:     if (scan_done) state_nxt = S_SAVE_RD;
      S_SAVE_RD:   state_nxt = S_SAVE_WAIT;
      S_SAVE_WAIT: if (wait_cnt == 2'(RD_LAT - 1)) state_nxt = S_CURSOR;
      S_CURSOR:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      middle_q     <= 1'b0;
      size_q       <= 1'b0;
      color_index  <= '0;
      brush_radius <= '0;
      pos_x        <= '0;
      pos_y        <= '0;
      last_x       <= '0;
      last_y       <= '0;
      mode         <= MODE_CURSOR;
      color_lat    <= '0;
      wait_cnt     <= '0;
      cap_pipe     <= '0;
      saved_bg     <= '0;
      saved_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      left_q   <= btn_left;
      right_q  <= btn_right;
      middle_q <= btn_middle;
      size_q   <= btn_size;

      if (btn_middle && !middle_q) color_index <= color_index + 1;
      if (btn_size && !size_q)
        brush_radius <= (brush_radius == RAD_W'(BRUSH_MAX)) ? '0 : brush_radius + 1;

      if (scan_start) begin
        pos_x     <= cur_x;
        pos_y     <= cur_y;
        mode      <= btn_left ? MODE_PAINT : (btn_right ? MODE_ERASE : MODE_CURSOR);
        color_lat <= COLOR_W'(palette(color_index));
      end

      if (state == S_SAVE_RD)        wait_cnt <= '0;
      else if (state == S_SAVE_WAIT) wait_cnt <= wait_cnt + 1;

      if (state == S_CURSOR) begin
        last_x <= pos_x;
        last_y <= pos_y;
      end

      // rd_en is itself registered, so the data window trails it by RD_LAT.
      cap_pipe <= (cap_pipe << 1) | RD_LAT'(rd_en);
      if (cap_pipe[RD_LAT-1]) begin
        saved_bg    <= rd_data;
        saved_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en           <= 1'b0;
      rd_bank         <= '0;
      rd_addr         <= '0;
      wr_en           <= 1'b0;
      wr_bank         <= '0;
      wr_addr         <= '0;
      wr_data         <= '0;
      paint_permanent <= 1'b0;
    end else begin
      rd_en           <= 1'b0;
      wr_en           <= 1'b0;
      paint_permanent <= 1'b0;
      case (state)
        S_RESTORE: if (saved_valid) begin
          wr_en   <= 1'b1;
          wr_bank <= bank_of(last_y);
          wr_addr <= addr_of(last_x, last_y);
          wr_data <= saved_bg;
        end
        S_BRUSH: if (scan_in_frame) begin
          wr_en           <= 1'b1;
          paint_permanent <= 1'b1;
          wr_bank         <= bank_of(scan_ty);
          wr_addr         <= addr_of(scan_tx, scan_ty);
          wr_data         <= (mode == MODE_ERASE) ? COLOR_W'(ERASE_COLOR) : color_lat;
        end
        S_SAVE_RD: begin
          rd_en   <= 1'b1;
          rd_bank <= bank_of(pos_y);
          rd_addr <= addr_of(pos_x, pos_y);
        end
        S_CURSOR: begin
          wr_en   <= 1'b1;
          wr_bank <= bank_of(pos_y);
          wr_addr <= addr_of(pos_x, pos_y);
          wr_data <= CURSOR_COLOR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_paint_brush.sv
// Directed bench for ctrl_paint_brush: a vector table of single-pixel events
// plus hand-written brush, erase, palette, radius-wrap and reset sequences.
module tb_ctrl_paint_brush;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic signed [8:0] PS2_Xdata = '0, PS2_Ydata = '0;
  logic              btn_left = 0, btn_right = 0, btn_middle = 0, btn_size = 0;
  logic              rd_en, wr_en, paint_permanent, busy;
  logic [0:0]        rd_bank, wr_bank;
  logic [10:0]       rd_addr, wr_addr;
  logic [11:0]       rd_data, wr_data;
  logic [1:0]        color_index;
  logic [1:0]        brush_radius;

  ctrl_paint_brush dut (
    .clk(clk), .reset(reset), .PS2_Xdata(PS2_Xdata), .PS2_Ydata(PS2_Ydata),
    .btn_left(btn_left), .btn_right(btn_right), .btn_middle(btn_middle),
    .btn_size(btn_size), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .paint_permanent(paint_permanent), .busy(busy),
    .color_index(color_index), .brush_radius(brush_radius)
  );

  always #5 clk = ~clk;

  // Framebuffer model, 1-cycle read latency; unwritten pixels read as ABC.
  logic [11:0] mem [0:4095];
  bit          vld [0:4095];
  always @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
      vld[{wr_bank, wr_addr}] <= 1'b1;
    end
    if (rd_en) rd_data <= vld[{rd_bank, rd_addr}] ? mem[{rd_bank, rd_addr}] : 12'hABC;
  end

  typedef struct { int bank; int addr; int data; bit perm; } wr_t;
  wr_t wr_q[$];
  int  rd_total = 0, busy_total = 0, rd_last_bank = 0, rd_last_addr = 0;

  always @(negedge clk) begin
    if (wr_en) wr_q.push_back('{int'(wr_bank), int'(wr_addr), int'(wr_data), paint_permanent});
    if (rd_en) begin
      rd_total     <= rd_total + 1;
      rd_last_bank <= int'(rd_bank);
      rd_last_addr <= int'(rd_addr);
    end
    if (busy) busy_total <= busy_total + 1;
  end

  int n_cmp = 0, n_bad = 0;
  int ev_start, ev_nwr, ev_busy, ev_rd;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic run_event(input int x, input int y, input bit l, input bit r, input int mids);
    int n, busy0, rd0;
    @(negedge clk);
    ev_start = wr_q.size();
    busy0 = busy_total;
    rd0 = rd_total;
    PS2_Xdata = 9'(x);
    PS2_Ydata = 9'(y);
    btn_left = l;
    btn_right = r;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check("busy_rise", int'(busy), 1);
    repeat (mids) begin
      btn_middle = 1; @(negedge clk);
      btn_middle = 0; @(negedge clk);
    end
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("busy_fall", int'(busy), 0);
    btn_left = 0;
    btn_right = 0;
    repeat (2) @(negedge clk);
    ev_nwr  = wr_q.size() - ev_start;
    ev_busy = busy_total - busy0;
    ev_rd   = rd_total - rd0;
  endtask

  task automatic pulse_size();
    @(negedge clk) btn_size = 1;
    @(negedge clk) btn_size = 0;
    @(negedge clk);
  endtask

  // Brush writes of the last event must cover a w-wide rectangle row by row.
  task automatic check_brush(input string name, input int bank, input int row0,
                             input int col0, input int w, input int data, input int nexp);
    int k = 0;
    for (int i = ev_start; i < wr_q.size(); i++) begin
      if (wr_q[i].perm) begin
        check({name, "_bank"}, wr_q[i].bank, bank);
        check({name, "_addr"}, wr_q[i].addr, (row0 + k / w) * 64 + col0 + k % w);
        check({name, "_data"}, wr_q[i].data, data);
        k++;
      end
    end
    check({name, "_count"}, k, nexp);
  endtask

  task automatic check_ends(input string name, input int fb, input int fa, input int fd,
                            input int cb, input int ca);
    if (ev_nwr > 0) begin
      check({name, "_first_bank"}, wr_q[ev_start].bank, fb);
      check({name, "_first_addr"}, wr_q[ev_start].addr, fa);
      check({name, "_first_data"}, wr_q[ev_start].data, fd);
      check({name, "_cur_bank"}, wr_q[$].bank, cb);
      check({name, "_cur_addr"}, wr_q[$].addr, ca);
      check({name, "_cur_data"}, wr_q[$].data, 0);
      check({name, "_cur_perm"}, int'(wr_q[$].perm), 0);
    end
  endtask

  typedef struct {
    int x; int y; bit left; bit right;
    int exp_busy; int nwr; int nperm;
    int f_bank; int f_addr; int f_data;
    int c_bank; int c_addr; int r_bank; int r_addr;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, found;
    vecs[0] = '{x:5,   y:5,   left:0, right:0, exp_busy:4, nwr:1, nperm:0,
                f_bank:0, f_addr:325,  f_data:'h000, c_bank:0, c_addr:325,  r_bank:0, r_addr:325};
    vecs[1] = '{x:6,   y:5,   left:0, right:0, exp_busy:4, nwr:2, nperm:0,
                f_bank:0, f_addr:325,  f_data:'hABC, c_bank:0, c_addr:326,  r_bank:0, r_addr:326};
    vecs[2] = '{x:-20, y:200, left:0, right:0, exp_busy:4, nwr:2, nperm:0,
                f_bank:0, f_addr:326,  f_data:'hABC, c_bank:1, c_addr:1984, r_bank:1, r_addr:1984};
    vecs[3] = '{x:0,   y:63,  left:1, right:0, exp_busy:5, nwr:3, nperm:1,
                f_bank:1, f_addr:1984, f_data:'hABC, c_bank:1, c_addr:1984, r_bank:1, r_addr:1984};
    vecs[4] = '{x:1,   y:63,  left:0, right:0, exp_busy:4, nwr:2, nperm:0,
                f_bank:1, f_addr:1984, f_data:'hF00, c_bank:1, c_addr:1985, r_bank:1, r_addr:1985};

    repeat (3) @(negedge clk);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_color", int'(color_index), 0);
    check("rst_radius", int'(brush_radius), 0);
    reset = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      string nm;
      int np;
      nm = $sformatf("vec%0d", i);
      run_event(vecs[i].x, vecs[i].y, vecs[i].left, vecs[i].right, 0);
      check({nm, "_busy"}, ev_busy, vecs[i].exp_busy);
      check({nm, "_nwr"}, ev_nwr, vecs[i].nwr);
      check({nm, "_nrd"}, ev_rd, 1);
      check({nm, "_rd_bank"}, rd_last_bank, vecs[i].r_bank);
      check({nm, "_rd_addr"}, rd_last_addr, vecs[i].r_addr);
      np = 0;
      for (int k = ev_start; k < wr_q.size(); k++) np += int'(wr_q[k].perm);
      check({nm, "_nperm"}, np, vecs[i].nperm);
      check_ends(nm, vecs[i].f_bank, vecs[i].f_addr, vecs[i].f_data,
                 vecs[i].c_bank, vecs[i].c_addr);
    end

    // Radius 1 red brush at (10,40): rows 39..41 = bank1 local rows 7..9.
    pulse_size();
    check("radius_1", int'(brush_radius), 1);
    run_event(10, 40, 1, 0, 0);
    check("paint_busy", ev_busy, 13);
    check("paint_nwr", ev_nwr, 11);
    check("paint_rd_addr", rd_last_addr, 522);
    check_ends("paint", 1, 1985, 'hABC, 1, 522);
    check_brush("paint", 1, 7, 9, 3, 'hF00, 9);
    run_event(11, 40, 0, 0, 0);
    check_ends("after_paint", 1, 522, 'hF00, 1, 523);

    // Radius 2 erase at the corner: only the 3x3 in-frame part is written.
    pulse_size();
    check("radius_2", int'(brush_radius), 2);
    run_event(0, 0, 0, 1, 0);
    check("erase_busy", ev_busy, 29);
    check("erase_nwr", ev_nwr, 11);
    check_ends("erase", 1, 523, 'hF00, 0, 0);
    check_brush("erase", 0, 0, 0, 3, 'hFFF, 9);

    // Palette edges during busy must not change the latched brush colour.
    pulse_size();
    check("radius_3", int'(brush_radius), 3);
    run_event(20, 20, 1, 0, 2);
    check("mid_busy", ev_busy, 53);
    check("mid_color_index", int'(color_index), 2);
    check_ends("mid", 0, 0, 'hFFF, 0, 20 * 64 + 20);
    check_brush("mid", 0, 17, 17, 7, 'hF00, 49);
    pulse_size();
    check("radius_wrap", int'(brush_radius), 0);

    // Reset in the middle of BRUSH.
    pulse_size();
    @(negedge clk);
    PS2_Xdata = 9'd30;
    PS2_Ydata = 9'd30;
    btn_left = 1;
    found = 0;
    n = 0;
    while (!found && n < 30) begin
      @(negedge clk);
      n++;
      if (wr_en && paint_permanent) found = 1;
    end
    check("rst_mid_brush_seen", found, 1);
    reset = 1;
    #1;
    check("rst_mid_wr_en", int'(wr_en), 0);
    check("rst_mid_perm", int'(paint_permanent), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_radius", int'(brush_radius), 0);
    @(negedge clk);
    btn_left = 0;
    PS2_Xdata = 9'd0;
    PS2_Ydata = 9'd0;
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    run_event(31, 30, 0, 0, 0);
    check("post_rst_nwr", ev_nwr, 1);
    check("post_rst_busy", ev_busy, 4);
    check_ends("post_rst", 0, 1951, 'h000, 0, 1951);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
